charging_arbiter: RTL and testbench
===================================

# charging_arbiter

Round-robin arbiter that shares the single packet-evaluation engine of the charging module between NREQ upstream packet sources (per-port classifiers, UL/DL queues). Each source presents a packet descriptor (id, length, counting policy, report word, UL flag) with a valid/ready handshake. The arbiter selects one source per transfer and forwards the descriptor through a one-entry output register to the engine's `out_*` inputs, honouring the engine's `out_rdy` backpressure.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `SW`, `$clog2(NREQ)`: width of the source index.
- `asclk`  in  1  clock; all logic is on the rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `in_pkt_id`  in  NREQ*96  packet ids; requester i occupies bits [i*96 +: 96].
- `in_pkt_len`  in  NREQ*16  packet lengths in bytes; requester i occupies bits [i*16 +: 16].
- `in_cnt_policy`  in  NREQ*3  counting policies; requester i occupies bits [i*3 +: 3].
- `in_cnt_report`  in  NREQ*22  report control words; requester i occupies bits [i*22 +: 22].
- `in_ul`  in  NREQ  uplink flag per requester.
- `in_vld`  in  NREQ  per-requester valid.
- `in_rdy`  out  NREQ  per-requester ready; one-hot or zero.
- `out_pkt_id`, `out_pkt_len`, `out_cnt_policy`, `out_cnt_report`, `out_ul`  out  96/16/3/22/1  registered descriptor to the evaluation engine.
- `out_src`  out  SW  index of the requester that supplied the current descriptor.
- `out_vld`  out  1  descriptor valid.
- `out_rdy`  in  1  engine accepts the descriptor.

## Operation
- Output register has two states:
  - EMPTY: `out_vld`=0.
  - FULL: `out_vld`=1.
- `load` = (EMPTY) or (FULL and `out_rdy`).
- When `load`=1 and any `in_vld` is set:
  - Grant index g is the first set `in_vld` bit searching upward from pointer `rr_ptr`, wrapping modulo NREQ.
  - `in_rdy` = one-hot(g).
  - On the clock edge, the descriptor of g, `out_src`=g and `out_vld`=1 are captured.
  - `rr_ptr` becomes (g+1) mod NREQ; if g = NREQ-1 it wraps to 0.
- When `load`=1 and no `in_vld` is set:
  - `in_rdy`=0.
  - If FULL and `out_rdy`, the register drains to EMPTY.
  - `rr_ptr` is unchanged.
- When FULL and `out_rdy`=0:
  - `in_rdy`=0.
  - All `out_*` and `out_src` hold stable.
  - `rr_ptr` is unchanged.
- `in_rdy` is combinational from `in_vld`, `rr_ptr`, `out_vld` and `out_rdy`; `in_rdy[i]` never depends on `in_rdy` of another requester.
- Requesters must hold their descriptor stable while `in_vld`=1 and `in_rdy`=0. The arbiter does not check this.
- Fairness: a requester that keeps `in_vld` asserted is granted within NREQ grants.
- The datapath does no arithmetic; fields pass through bit-exact.

## Timing
- Reset (asynchronous, effective immediately) sets:
  - `out_vld`=0
  - `out_pkt_id`, `out_pkt_len`, `out_cnt_policy`, `out_cnt_report`, `out_ul`, `out_src` = 0
  - `rr_ptr`=0
  - `in_rdy`=0 while reset is asserted.
- Latency: a descriptor accepted at edge N (`in_vld`&`in_rdy`) shows `out_vld`=1 after edge N.
- Throughput: one descriptor per cycle while `out_rdy`=1; a simultaneous drain and reload costs no bubble.
- Reset mid-operation: the held descriptor is discarded without reaching the engine. Requesters must re-present it; no ready was given for it after reset.
- `out_rdy` while `out_vld`=0 has no effect.

## Configuration
- `ARB_UL_PRIO_EN` defined:
  - Arbitration runs in two tiers.
  - If any requester has `in_vld`&`in_ul`, the round-robin search from `rr_ptr` covers only those requesters.
  - Otherwise it covers all valid requesters.
  - `rr_ptr` update rule is unchanged.
  - A continuous UL stream may starve DL requesters; this is intended.
- `ARB_UL_PRIO_EN` undefined: pure round-robin; `in_ul` is only passed through.

## Test plan
- Reset: hold `aresetn`=0 with `in_vld`=4'b1111 -> `out_vld`=0, `in_rdy`=4'b0000, `out_src`=0. Assert `aresetn`=0 again while FULL -> `out_vld` falls immediately.
- Single source: requester 2 valid continuously with `in_pkt_id`=9, `in_pkt_len`=16'd34464, `in_cnt_policy`=4, `in_cnt_report`=22'b0011111100000000001001, `in_ul`=1; `out_rdy`=1 -> `in_rdy`=4'b0100 every cycle; `out_vld`=1 one cycle after the first `in_vld`; `out_src`=2; fields bit-exact.
- Round robin: all four requesters valid with distinct ids 0..3, `out_rdy`=1 -> `out_src` sequence 0,1,2,3,0,1 with no bubbles.
- Backpressure: FULL with `out_src`=1, `out_rdy`=0 for 5 cycles -> `in_rdy`=0 and outputs stable throughout. On the cycle `out_rdy` goes to 1, `in_rdy`=4'b0100 (requesters 2,3 valid) and the next `out_src`=2.
- Wrap/empty: only requester 3 valid once, then none -> `rr_ptr` wraps to 0; `out_vld` drops one cycle after the drain handshake. A later request from requester 0 is granted first.
- Priority: requester 0 DL and requester 3 UL, both valid, `out_rdy`=1:
  - With `ARB_UL_PRIO_EN` -> `out_src` = 3,3,3...
  - Without it -> `out_src` = 0,3,0,3.

Source files
------------

// File: rtl/charging_arbiter.sv
// charging_arbiter: round-robin arbiter in front of the charging packet-evaluation engine.
// NREQ sources offer packet descriptors over valid/ready. One source is granted per
// transfer, and its descriptor is captured in a one-entry output register. That register
// is drained by the engine's out_rdy. If the register is drained and reloaded in the same
// cycle, no bubble is inserted.
//
// Optional feature: define ARB_UL_PRIO_EN for two-tier arbitration. When any uplink
// requester is valid, only uplink requesters take part in the round-robin search. When
// the macro is left undefined, arbitration is pure round robin and in_ul is only passed
// through.
module charging_arbiter #(
    parameter int NREQ = 4,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic                 asclk,
    input  logic                 aresetn,
    input  logic [NREQ*96-1:0]   in_pkt_id,
    input  logic [NREQ*16-1:0]   in_pkt_len,
    input  logic [NREQ*3-1:0]    in_cnt_policy,
    input  logic [NREQ*22-1:0]   in_cnt_report,
    input  logic [NREQ-1:0]      in_ul,
    input  logic [NREQ-1:0]      in_vld,
    output logic [NREQ-1:0]      in_rdy,
    output logic [95:0]          out_pkt_id,
    output logic [15:0]          out_pkt_len,
    output logic [2:0]           out_cnt_policy,
    output logic [21:0]          out_cnt_report,
    output logic                 out_ul,
    output logic [SW-1:0]        out_src,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    // State of the output register: it is either empty or holds one descriptor.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_rr_ptr;
    logic [SW-1:0]     w_ptr_nxt;
    logic [SW-1:0]     w_grant;
    logic              w_any;
    logic              w_load;
    logic              w_take;
    logic [NREQ-1:0]   w_cand;
    logic [NREQ-1:0]   w_onehot;
    int                w_idx;

    logic [95:0]       r_pkt_id;
    logic [15:0]       r_pkt_len;
    logic [2:0]        r_cnt_policy;
    logic [21:0]       r_cnt_report;
    logic              r_ul;
    logic [SW-1:0]     r_src;

    // The register can accept a new descriptor when it is empty, or when the
    // engine is taking the current descriptor in this same cycle.
    assign w_load = (r_state == ST_EMPTY) || out_rdy;
    assign w_take = w_load && w_any;

`ifdef ARB_UL_PRIO_EN
    // Candidate set: restrict the search to valid uplink requesters whenever
    // at least one exists. Otherwise every valid requester is a candidate.
    always_comb begin
        w_cand = in_vld;
        if (|(in_vld & in_ul))
            w_cand = in_vld & in_ul;
    end
`else
    // Candidate set: every valid requester takes part.
    always_comb begin
        w_cand = in_vld;
    end
`endif

    // Round-robin search: pick the first candidate at or above rr_ptr,
    // wrapping modulo NREQ. NREQ need not be a power of two.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ)
                w_idx = w_idx - NREQ;
            if (!w_any && w_cand[w_idx[SW-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx[SW-1:0];
            end
        end
    end

    // Ready is a one-hot of the grant. It is gated by load and by reset, so that
    // nothing can be handed over while reset is held.
    always_comb begin
        w_onehot = NREQ'(1) << w_grant;
        in_rdy   = '0;
        if (aresetn && w_take)
            in_rdy = w_onehot;
    end

    // After a grant, the pointer moves one past the winner. An explicit wrap
    // keeps this correct for any NREQ.
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_take)
            w_ptr_nxt = (w_grant == SW'(NREQ - 1)) ? '0 : w_grant + SW'(1);
    end

    // Next state of the output register: fill it on a grant, drain it when the
    // engine takes the descriptor and nothing replaces it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
    end

    // State and round-robin pointer registers.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_EMPTY;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Descriptor register: capture the granted source's fields bit-exact.
    // The register holds its value while the engine stalls.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_id     <= '0;
            r_pkt_len    <= '0;
            r_cnt_policy <= '0;
            r_cnt_report <= '0;
            r_ul         <= 1'b0;
            r_src        <= '0;
        end else if (w_take) begin
            r_pkt_id     <= in_pkt_id[w_grant*96 +: 96];
            r_pkt_len    <= in_pkt_len[w_grant*16 +: 16];
            r_cnt_policy <= in_cnt_policy[w_grant*3 +: 3];
            r_cnt_report <= in_cnt_report[w_grant*22 +: 22];
            r_ul         <= in_ul[w_grant];
            r_src        <= w_grant;
        end
    end

    assign out_vld        = (r_state == ST_FULL);
    assign out_pkt_id     = r_pkt_id;
    assign out_pkt_len    = r_pkt_len;
    assign out_cnt_policy = r_cnt_policy;
    assign out_cnt_report = r_cnt_report;
    assign out_ul         = r_ul;
    assign out_src        = r_src;

endmodule

// File: tb/tb_charging_arbiter.sv
// Directed testbench for charging_arbiter with NREQ=4. It follows the expected
// outputs for both builds, with and without ARB_UL_PRIO_EN.
module tb_charging_arbiter;

    localparam int NREQ = 4;
    localparam int SW   = 2;

    logic                asclk = 1'b0;
    logic                aresetn;
    logic [NREQ*96-1:0]  in_pkt_id;
    logic [NREQ*16-1:0]  in_pkt_len;
    logic [NREQ*3-1:0]   in_cnt_policy;
    logic [NREQ*22-1:0]  in_cnt_report;
    logic [NREQ-1:0]     in_ul;
    logic [NREQ-1:0]     in_vld;
    logic [NREQ-1:0]     in_rdy;
    logic [95:0]         out_pkt_id;
    logic [15:0]         out_pkt_len;
    logic [2:0]          out_cnt_policy;
    logic [21:0]         out_cnt_report;
    logic                out_ul;
    logic [SW-1:0]       out_src;
    logic                out_vld;
    logic                out_rdy;

    logic [95:0] id_a  [NREQ];
    logic [15:0] len_a [NREQ];
    logic [2:0]  pol_a [NREQ];
    logic [21:0] rep_a [NREQ];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] ul;
        logic       rdy;
        logic [3:0] exp_rdy;
        logic       exp_ovld;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl [32];
    int   nv = 0;

    charging_arbiter #(.NREQ(NREQ)) dut (
        .asclk          (asclk),
        .aresetn        (aresetn),
        .in_pkt_id      (in_pkt_id),
        .in_pkt_len     (in_pkt_len),
        .in_cnt_policy  (in_cnt_policy),
        .in_cnt_report  (in_cnt_report),
        .in_ul          (in_ul),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .out_pkt_id     (out_pkt_id),
        .out_pkt_len    (out_pkt_len),
        .out_cnt_policy (out_cnt_policy),
        .out_cnt_report (out_cnt_report),
        .out_ul         (out_ul),
        .out_src        (out_src),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy)
    );

    always #5 asclk = ~asclk;

    // Pack the per-requester field arrays onto the flat input buses.
    always_comb begin
        in_pkt_id     = '0;
        in_pkt_len    = '0;
        in_cnt_policy = '0;
        in_cnt_report = '0;
        for (int i = 0; i < NREQ; i++) begin
            in_pkt_id[i*96 +: 96]    = id_a[i];
            in_pkt_len[i*16 +: 16]   = len_a[i];
            in_cnt_policy[i*3 +: 3]  = pol_a[i];
            in_cnt_report[i*22 +: 22] = rep_a[i];
        end
    end

    // Watchdog: the test is cycle-bounded, so this should never fire.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] vld, input logic [3:0] ul, input logic rdy,
                       input logic [3:0] er, input logic eo, input logic [1:0] es);
        tbl[nv] = '{vld, ul, rdy, er, eo, es};
        nv++;
    endtask

    // Drive one vector, check the combinational ready, then check the
    // registered outputs just after the clock edge.
    task automatic run_vec(input vec_t v, input int n);
        in_vld  = v.vld;
        in_ul   = v.ul;
        out_rdy = v.rdy;
        #1;
        chk($sformatf("v%0d in_rdy", n), 128'(in_rdy), 128'(v.exp_rdy));
        @(posedge asclk);
        #1;
        chk($sformatf("v%0d out_vld", n), 128'(out_vld), 128'(v.exp_ovld));
        if (v.exp_ovld) begin
            chk($sformatf("v%0d out_src", n), 128'(out_src), 128'(v.exp_src));
            chk($sformatf("v%0d out_pkt_id", n), 128'(out_pkt_id), 128'(v.exp_src));
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            id_a[i]  = 96'(i);
            len_a[i] = 16'(100 + i);
            pol_a[i] = 3'(i);
            rep_a[i] = 22'(i);
        end

        // Round robin over all four requesters, with no bubbles.
        add(4'b1111, 4'b0000, 1, 4'b0001, 1, 0);
        add(4'b1111, 4'b0000, 1, 4'b0010, 1, 1);
        add(4'b1111, 4'b0000, 1, 4'b0100, 1, 2);
        add(4'b1111, 4'b0000, 1, 4'b1000, 1, 3);
        add(4'b1111, 4'b0000, 1, 4'b0001, 1, 0);
        add(4'b1111, 4'b0000, 1, 4'b0010, 1, 1);
        // Backpressure: the register holds source 1 for 5 stalled cycles.
        for (int i = 0; i < 5; i++)
            add(4'b1100, 4'b0000, 0, 4'b0000, 1, 1);
        add(4'b1100, 4'b0000, 1, 4'b0100, 1, 2);
        // Wrap and empty: source 3 alone, then a drain, then an idle cycle.
        add(4'b1000, 4'b0000, 1, 4'b1000, 1, 3);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
        // The pointer wrapped to 0, so source 0 beats source 3. out_rdy is ignored while empty.
        add(4'b1001, 4'b0000, 0, 4'b0001, 1, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
        // Bring the pointer back to 0 with a grant to source 3.
        add(4'b1000, 4'b0000, 1, 4'b1000, 1, 3);
        // Source 0 is downlink and source 3 is uplink, both valid.
`ifdef ARB_UL_PRIO_EN
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
`else
        add(4'b1001, 4'b1000, 1, 4'b0001, 1, 0);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
        add(4'b1001, 4'b1000, 1, 4'b0001, 1, 0);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 3);
`endif

        // Reset with every requester valid.
        aresetn = 1'b0;
        in_vld  = 4'b1111;
        in_ul   = 4'b0000;
        out_rdy = 1'b1;
        repeat (2) @(posedge asclk);
        #1;
        chk("rst out_vld", 128'(out_vld), 128'(0));
        chk("rst in_rdy", 128'(in_rdy), 128'(0));
        chk("rst out_src", 128'(out_src), 128'(0));
        chk("rst out_pkt_id", 128'(out_pkt_id), 128'(0));
        aresetn = 1'b1;

        for (int n = 0; n < nv; n++)
            run_vec(tbl[n], n);

        // Reset while the register is full: out_vld must drop without a clock edge.
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst out_vld", 128'(out_vld), 128'(0));
        chk("midrst in_rdy", 128'(in_rdy), 128'(0));
        chk("midrst out_src", 128'(out_src), 128'(0));
        @(posedge asclk);
        #1;
        in_vld  = 4'b0000;
        aresetn = 1'b1;

        // Single source: requester 2 with specific fields, checked bit-exact.
        id_a[2]  = 96'd9;
        len_a[2] = 16'd34464;
        pol_a[2] = 3'd4;
        rep_a[2] = 22'b0011111100000000001001;
        in_vld   = 4'b0100;
        in_ul    = 4'b0100;
        out_rdy  = 1'b1;
        #1;
        chk("single in_rdy first", 128'(in_rdy), 128'(4'b0100));
        chk("single out_vld before edge", 128'(out_vld), 128'(0));
        @(posedge asclk);
        #1;
        chk("single out_vld", 128'(out_vld), 128'(1));
        chk("single out_src", 128'(out_src), 128'(2));
        chk("single out_pkt_id", 128'(out_pkt_id), 128'(96'd9));
        chk("single out_pkt_len", 128'(out_pkt_len), 128'(16'd34464));
        chk("single out_cnt_policy", 128'(out_cnt_policy), 128'(3'd4));
        chk("single out_cnt_report", 128'(out_cnt_report), 128'(22'b0011111100000000001001));
        chk("single out_ul", 128'(out_ul), 128'(1));
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("single in_rdy c%0d", c), 128'(in_rdy), 128'(4'b0100));
            @(posedge asclk);
            #1;
            chk($sformatf("single out_vld c%0d", c), 128'(out_vld), 128'(1));
            chk($sformatf("single out_src c%0d", c), 128'(out_src), 128'(2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
